audio_adc_deserializer: RTL and testbench
=========================================

// Module: audio_adc_deserializer
// PURPOSE
// - Receive side of the codec serial audio link. Oversamples codec BCLK/LRCK/ADCDAT in the system clock domain.
// - Deserializes MSB-first two's-complement left and right words.
// - Presents them as a parallel stereo pair with a one-cycle valid strobe.
// - Sits between codec pins AUD_BCLK/AUD_ADCLRCK/AUD_ADCDAT and DSP blocks (DDS, noise, filters).
// - Replaces the ad-hoc ADC capture in the combined DAC/ADC block.
// PARAMETERS
// - DATA_W          16   captured bits per channel; extra slot bits are ignored.
// - I2S_MODE        0    0 = left-justified (MSB on first BCLK after LRCK edge); 1 = I2S (MSB one BCLK later).
// - LRCK_LEFT_HIGH  1    1 = LRCK high carries left channel; 0 = LRCK low carries left.
// PORTS
// - iCLK         in   1       system clock (CLOCK_50); must be >= 4x BCLK.
// - iRST_N       in   1       reset, synchronous, active-low.
// - iAUD_BCLK    in   1       codec bit clock, asynchronous to iCLK.
// - iAUD_LRCK    in   1       codec ADC LR clock, asynchronous.
// - iAUD_ADCDAT  in   1       codec serial ADC data, asynchronous.
// - oAUD_inL     out  DATA_W  last complete left sample (signed).
// - oAUD_inR     out  DATA_W  last complete right sample (signed).
// - oSAMPLE_VLD  out  1       1-cycle pulse; oAUD_inL and oAUD_inR updated together on this cycle.
// - oFRAME_ERR   out  1       1-cycle pulse; a channel slot ended before DATA_W bits were captured.
// BEHAVIOUR
// - Clock and reset: one clock (iCLK); reset is synchronous and active-low (iRST_N). Polarity and synchronicity are fixed.
// - Input sync: all three inputs pass through 2-FF synchronizers plus one history flop.
// - BCLK rise event: sync=1 and history=0. Events occur with a fixed 3-cycle latency from pin to event.
// - Data sampling: data is sampled only on BCLK rise events. LRCK is also sampled on rise events.
// - Slot start: the LRCK sampled now differs from the LRCK sampled at the previous rise.
// - FSM states:
//   - IDLE: after reset. Ignores bits until the first slot start, so no partial slot is ever captured.
//     On slot start, go to SKIP if I2S_MODE, else to SHIFT with this bit as the MSB.
//   - SKIP: discard exactly one bit, then go to SHIFT.
//   - SHIFT: shift in one bit per rise event; bitcnt counts 0..DATA_W-1.
//     When the DATA_W-th bit is shifted, latch the word into the channel hold register and go to DONE.
//   - DONE: ignore further bits until the next slot start. On slot start, go to SKIP or SHIFT as from IDLE.
// - Slot start while in SHIFT or SKIP (short slot):
//   - Discard the partial word and pulse oFRAME_ERR on the same cycle.
//   - Clear the left-valid flag.
//   - Restart capture for the new channel in the same event.
// - Pairing:
//   - Left completion sets the left-valid flag.
//   - Right completion with the left-valid flag set: on the next iCLK, update oAUD_inL and oAUD_inR and pulse oSAMPLE_VLD.
//     Then clear the flag.
//   - Right completion without the flag: the word is dropped silently, with no valid pulse and no error.
// - Channel selection: channel = LRCK XOR ~LRCK_LEFT_HIGH, latched at slot start.
// - Latency: oSAMPLE_VLD is asserted 1 iCLK after the rise event carrying the right LSB (3 + 1 cycles from the pin edge).
// - Width: words are stored raw with no sign extension or rounding. DATA_W > slot width never completes and raises oFRAME_ERR every slot.
// - Reset values: oAUD_inL = 0, oAUD_inR = 0, oSAMPLE_VLD = 0, oFRAME_ERR = 0, FSM = IDLE, flags cleared.
// - Reset mid-frame: partial data is discarded; capture resumes at the next slot start.
// - Outputs hold their value between valid pulses.
// CONFIGURATION
// - Macro: AUDIO_RX_PEAK_EN.
// - Defined: adds ports iPEAK_CLR (in, 1) and oPEAK_L/oPEAK_R (out, DATA_W-1, unsigned).
//   - On each oSAMPLE_VLD, peak = max(peak, |sample|). The magnitude of -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
//   - iPEAK_CLR zeroes both peaks.
//   - If iPEAK_CLR coincides with a valid sample, peak = |sample|.
//   - Peaks reset to 0.
// - Undefined: these ports and their logic do not exist; all other behaviour is identical.
// STRUCTURE
// - Package audio_rx_pkg holds:
//   - The FSM state enum (IDLE, SKIP, SHIFT, DONE).
//   - Channel constants CH_LEFT and CH_RIGHT.
//   - Format localparams FMT_LJ and FMT_I2S.
// - Sub-module audio_rx_edge_sync: 2-FF synchronizer, history flop and rise/fall event outputs.
//   Instantiated for BCLK and LRCK; ADCDAT uses the synchronizer path only, keeping alignment equal.
// TESTING
// - Default params, BCLK = 50MHz/16, L = 16'h8001, R = 16'h7FFE -> one oSAMPLE_VLD.
//   oAUD_inL = 8001, oAUD_inR = 7FFE; no oFRAME_ERR.
// - Reset released mid-right-slot -> no valid for that partial frame; the next full frame (L = 1234, R = ABCD) is reported exactly.
// - I2S_MODE = 1, 32-bit slots, L = 16'hFFFF, R = 16'h0000 -> valid with the correct words.
//   The 16 trailing bits per slot are ignored.
// - LRCK toggles after 10 bits of left -> oFRAME_ERR pulse; the following right word is dropped with no valid.
//   The next full frame is valid.
// - LRCK_LEFT_HIGH = 0 with the L/R stimulus of test 1 -> channels map correctly (L = 8001, R = 7FFE).
// - AUDIO_RX_PEAK_EN: samples L = -32768, then 100, then iPEAK_CLR coinciding with L = -5.
//   -> oPEAK_L = 7FFF, then 7FFF, then 0005.

Source files
------------

// File: rtl/audio_adc_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// audio_rx_pkg
// Shared types and constants for the codec ADC receive path.
//   rx_state_t       : capture FSM state encoding
//   CH_LEFT/CH_RIGHT : channel code latched at slot start
//   FMT_LJ/FMT_I2S   : values for the I2S_MODE parameter
// ----------------------------------------------------------------------------
package audio_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_t;

    localparam logic CH_LEFT  = 1'b1;
    localparam logic CH_RIGHT = 1'b0;

    localparam int FMT_LJ  = 0;
    localparam int FMT_I2S = 1;

endpackage

// File: rtl/audio_adc_deserializer_if.sv
// ----------------------------------------------------------------------------
// audio_adc_deserializer_if
// Codec pin inputs and parallel stereo sample outputs of the ADC receiver.
//   iAUD_BCLK / iAUD_LRCK / iAUD_ADCDAT : codec pins (asynchronous)
//   oAUD_inL / oAUD_inR                 : last complete stereo pair
//   oSAMPLE_VLD                         : one-cycle pair-updated strobe
//   oFRAME_ERR                          : one-cycle short-slot strobe
// Optional (AUDIO_RX_PEAK_EN): iPEAK_CLR, oPEAK_L, oPEAK_R.
// slave modport = receiver, master modport = pin driver / sample consumer.
// ----------------------------------------------------------------------------
interface audio_adc_deserializer_if #(
    parameter int DATA_W = 16
);
    logic              iAUD_BCLK;
    logic              iAUD_LRCK;
    logic              iAUD_ADCDAT;
    logic [DATA_W-1:0] oAUD_inL;
    logic [DATA_W-1:0] oAUD_inR;
    logic              oSAMPLE_VLD;
    logic              oFRAME_ERR;
`ifdef AUDIO_RX_PEAK_EN
    logic              iPEAK_CLR;
    logic [DATA_W-2:0] oPEAK_L;
    logic [DATA_W-2:0] oPEAK_R;

    modport slave (
        input  iAUD_BCLK, iAUD_LRCK, iAUD_ADCDAT, iPEAK_CLR,
        output oAUD_inL, oAUD_inR, oSAMPLE_VLD, oFRAME_ERR, oPEAK_L, oPEAK_R
    );
    modport master (
        output iAUD_BCLK, iAUD_LRCK, iAUD_ADCDAT, iPEAK_CLR,
        input  oAUD_inL, oAUD_inR, oSAMPLE_VLD, oFRAME_ERR, oPEAK_L, oPEAK_R
    );
`else
    modport slave (
        input  iAUD_BCLK, iAUD_LRCK, iAUD_ADCDAT,
        output oAUD_inL, oAUD_inR, oSAMPLE_VLD, oFRAME_ERR
    );
    modport master (
        output iAUD_BCLK, iAUD_LRCK, iAUD_ADCDAT,
        input  oAUD_inL, oAUD_inR, oSAMPLE_VLD, oFRAME_ERR
    );
`endif
endinterface

// File: rtl/audio_adc_deserializer_edge_sync.sv
// ----------------------------------------------------------------------------
// audio_rx_edge_sync
// Two-flop synchronizer plus history flop for one asynchronous codec pin.
//   iCLK, iRST_N : system clock, synchronous active-low reset
//   i_async      : raw pin
//   o_sync       : synchronized level
//   o_rise       : sync=1 and history=0 (valid for one cycle)
//   o_fall       : sync=0 and history=1 (valid for one cycle)
// ----------------------------------------------------------------------------
module audio_rx_edge_sync (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_hist;
    assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/audio_adc_deserializer.sv
// ----------------------------------------------------------------------------
// audio_adc_deserializer
// Oversampling receiver for the codec serial ADC link. BCLK/LRCK/ADCDAT are
// synchronized into iCLK, words are shifted in MSB-first on BCLK rise events
// and presented as a stereo pair with a one-cycle valid strobe.
//   iCLK   : system clock, >= 4x BCLK
//   iRST_N : synchronous active-low reset
//   aud    : audio_adc_deserializer_if.slave (pins in, samples out)
// Parameters: DATA_W (>= 2), I2S_MODE (FMT_LJ/FMT_I2S), LRCK_LEFT_HIGH.
// Macro AUDIO_RX_PEAK_EN adds per-channel peak-magnitude tracking.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for the first slot start
// ST_SKIP  | I2S: slot-start bit discarded, next bit is the MSB
// ST_SHIFT | shifting word bits, r_bitcnt = bits already captured
// ST_DONE  | word complete, ignoring trailing slot bits
// ----------------------------------------------------------------------------
module audio_adc_deserializer
    import audio_rx_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int I2S_MODE       = FMT_LJ,
    parameter int LRCK_LEFT_HIGH = 1
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    audio_adc_deserializer_if.slave  aud
);
    localparam int              CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic            LEFT_HIGH = (LRCK_LEFT_HIGH != 0);

    logic w_bclk_sync, w_bclk_rise, w_bclk_fall;
    logic w_lrck, w_lrck_rise, w_lrck_fall;
    logic w_unused_edges;

    audio_rx_edge_sync u_bclk_sync (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .i_async (aud.iAUD_BCLK),
        .o_sync  (w_bclk_sync),
        .o_rise  (w_bclk_rise),
        .o_fall  (w_bclk_fall)
    );

    audio_rx_edge_sync u_lrck_sync (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .i_async (aud.iAUD_LRCK),
        .o_sync  (w_lrck),
        .o_rise  (w_lrck_rise),
        .o_fall  (w_lrck_fall)
    );

    assign w_unused_edges = ^{w_bclk_sync, w_bclk_fall, w_lrck_rise, w_lrck_fall};

    // Data takes the same two-flop depth as the clocks so a rise event sees
    // the bit that was on the pin when BCLK rose.
    logic r_dat_meta;
    logic r_dat_sync;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_dat_meta <= 1'b0;
            r_dat_sync <= 1'b0;
        end else begin
            r_dat_meta <= aud.iAUD_ADCDAT;
            r_dat_sync <= r_dat_meta;
        end
    end

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_ch;
    logic              r_lrck_prev;
    logic              r_lrck_seen;
    logic              r_left_vld;
    logic              r_pend;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic [DATA_W-1:0] r_out_l;
    logic [DATA_W-1:0] r_out_r;
    logic              r_vld;
    logic              r_frame_err;

    logic              w_slot_start;
    logic              w_ch_now;
    logic [DATA_W-1:0] w_word;

    // The very first rise after reset only records LRCK, so a slot already in
    // progress at reset release can never look like a slot start.
    assign w_slot_start = w_bclk_rise & r_lrck_seen & (w_lrck != r_lrck_prev);
    assign w_ch_now     = w_lrck ^ ~LEFT_HIGH;
    assign w_word       = {r_shift[DATA_W-2:0], r_dat_sync};

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_ch        <= CH_LEFT;
            r_lrck_prev <= 1'b0;
            r_lrck_seen <= 1'b0;
            r_left_vld  <= 1'b0;
            r_pend      <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_out_l     <= '0;
            r_out_r     <= '0;
            r_vld       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_pend      <= 1'b0;
            r_vld       <= r_pend;
            if (r_pend) begin
                r_out_l <= r_hold_l;
                r_out_r <= r_hold_r;
            end

            if (w_bclk_rise) begin
                r_lrck_prev <= w_lrck;
                r_lrck_seen <= 1'b1;

                if (w_slot_start) begin
                    if (r_state == ST_SHIFT || r_state == ST_SKIP) begin
                        r_frame_err <= 1'b1;
                        r_left_vld  <= 1'b0;
                    end
                    r_ch <= w_ch_now;
                    if (I2S_MODE == FMT_I2S) begin
                        r_state <= ST_SKIP;
                    end else begin
                        r_shift  <= {{(DATA_W-1){1'b0}}, r_dat_sync};
                        r_bitcnt <= CNT_W'(1);
                        r_state  <= ST_SHIFT;
                    end
                end else begin
                    case (r_state)
                        ST_SKIP: begin
                            r_shift  <= {{(DATA_W-1){1'b0}}, r_dat_sync};
                            r_bitcnt <= CNT_W'(1);
                            r_state  <= ST_SHIFT;
                        end
                        ST_SHIFT: begin
                            r_shift <= w_word;
                            if (r_bitcnt == LAST_BIT) begin
                                r_state <= ST_DONE;
                                if (r_ch == CH_LEFT) begin
                                    r_hold_l   <= w_word;
                                    r_left_vld <= 1'b1;
                                end else if (r_ch == CH_RIGHT && r_left_vld) begin
                                    r_hold_r   <= w_word;
                                    r_pend     <= 1'b1;
                                    r_left_vld <= 1'b0;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign aud.oAUD_inL    = r_out_l;
    assign aud.oAUD_inR    = r_out_r;
    assign aud.oSAMPLE_VLD = r_vld;
    assign aud.oFRAME_ERR  = r_frame_err;

`ifdef AUDIO_RX_PEAK_EN
    // |-2^(DATA_W-1)| does not fit DATA_W-1 bits, so it saturates.
    function automatic logic [DATA_W-2:0] f_mag(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] n;
        n = -s;
        if (!s[DATA_W-1])
            return s[DATA_W-2:0];
        else if (s == {1'b1, {(DATA_W-1){1'b0}}})
            return {(DATA_W-1){1'b1}};
        else
            return n[DATA_W-2:0];
    endfunction

    logic [DATA_W-2:0] r_peak_l;
    logic [DATA_W-2:0] r_peak_r;
    logic [DATA_W-2:0] w_mag_l;
    logic [DATA_W-2:0] w_mag_r;

    assign w_mag_l = f_mag(r_hold_l);
    assign w_mag_r = f_mag(r_hold_r);

    // Peaks follow the cycle on which the outputs update; a clear on that
    // same cycle restarts the peak from the new sample.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end else if (r_pend) begin
            if (aud.iPEAK_CLR || w_mag_l > r_peak_l) r_peak_l <= w_mag_l;
            if (aud.iPEAK_CLR || w_mag_r > r_peak_r) r_peak_r <= w_mag_r;
        end else if (aud.iPEAK_CLR) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end
    end

    assign aud.oPEAK_L = r_peak_l;
    assign aud.oPEAK_R = r_peak_r;
`endif

endmodule

// File: tb/tb_audio_adc_deserializer.sv
module tb_audio_adc_deserializer;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic bclk     = 1'b0;
    logic lrck     = 1'b0;
    logic dat      = 1'b0;
    logic peak_clr = 1'b0;

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    audio_adc_deserializer_if #(.DATA_W(16)) aud0 ();
    audio_adc_deserializer_if #(.DATA_W(16)) aud1 ();
    audio_adc_deserializer_if #(.DATA_W(16)) aud2 ();

    assign aud0.iAUD_BCLK   = bclk;
    assign aud0.iAUD_LRCK   = lrck;
    assign aud0.iAUD_ADCDAT = dat;
    assign aud1.iAUD_BCLK   = bclk;
    assign aud1.iAUD_LRCK   = lrck;
    assign aud1.iAUD_ADCDAT = dat;
    // Left-low instance sees inverted LRCK, so the same frames map to the same channels.
    assign aud2.iAUD_BCLK   = bclk;
    assign aud2.iAUD_LRCK   = ~lrck;
    assign aud2.iAUD_ADCDAT = dat;
`ifdef AUDIO_RX_PEAK_EN
    assign aud0.iPEAK_CLR = peak_clr;
    assign aud1.iPEAK_CLR = 1'b0;
    assign aud2.iPEAK_CLR = 1'b0;
`endif

    audio_adc_deserializer #(.DATA_W(16), .I2S_MODE(0), .LRCK_LEFT_HIGH(1)) dut0 (
        .iCLK(clk), .iRST_N(rst_n), .aud(aud0.slave));
    audio_adc_deserializer #(.DATA_W(16), .I2S_MODE(1), .LRCK_LEFT_HIGH(1)) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .aud(aud1.slave));
    audio_adc_deserializer #(.DATA_W(16), .I2S_MODE(0), .LRCK_LEFT_HIGH(0)) dut2 (
        .iCLK(clk), .iRST_N(rst_n), .aud(aud2.slave));

    int          vcnt  [3] = '{0, 0, 0};
    int          ecnt  [3] = '{0, 0, 0};
    int          vcyc  [3] = '{0, 0, 0};
    logic [15:0] lastl [3];
    logic [15:0] lastr [3];

    always @(negedge clk) begin
        if (aud0.oSAMPLE_VLD === 1'b1) begin
            vcnt[0]++; vcyc[0] = cyc; lastl[0] = aud0.oAUD_inL; lastr[0] = aud0.oAUD_inR;
        end
        if (aud1.oSAMPLE_VLD === 1'b1) begin
            vcnt[1]++; vcyc[1] = cyc; lastl[1] = aud1.oAUD_inL; lastr[1] = aud1.oAUD_inR;
        end
        if (aud2.oSAMPLE_VLD === 1'b1) begin
            vcnt[2]++; vcyc[2] = cyc; lastl[2] = aud2.oAUD_inL; lastr[2] = aud2.oAUD_inR;
        end
        if (aud0.oFRAME_ERR === 1'b1) ecnt[0]++;
        if (aud1.oFRAME_ERR === 1'b1) ecnt[1]++;
        if (aud2.oFRAME_ERR === 1'b1) ecnt[2]++;
    end

    // One BCLK period = 16 iCLK; pins change with BCLK low, sampled at its rise.
    task automatic send_bit(input logic l, input logic d);
        bclk = 1'b0; lrck = l; dat = d;
        repeat (8) @(negedge clk);
        bclk = 1'b1; last_rise_cyc = cyc;
        repeat (8) @(negedge clk);
    endtask

    // Filler bits: I2S lead bit is ~MSB, trailing bits alternate, so any
    // misalignment corrupts the captured word.
    task automatic send_slot(input logic l, input logic [15:0] word, input int len, input bit i2s);
        for (int k = 0; k < len; k++) begin
            int   idx;
            logic b;
            idx = i2s ? k - 1 : k;
            if (idx < 0)       b = ~word[15];
            else if (idx < 16) b = word[15 - idx];
            else               b = (k % 2 == 1);
            send_bit(l, b);
        end
    endtask

    task automatic send_frame(input logic [15:0] l_w, input logic [15:0] r_w, input int len, input bit i2s);
        send_slot(1'b1, l_w, len, i2s);
        send_slot(1'b0, r_w, len, i2s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (aud0.oAUD_inL !== 16'h0) begin errors++; $display("FAIL rst_inL got %h exp 0000", aud0.oAUD_inL); end
        checks++; if (aud0.oAUD_inR !== 16'h0) begin errors++; $display("FAIL rst_inR got %h exp 0000", aud0.oAUD_inR); end
        checks++; if (aud0.oSAMPLE_VLD !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", aud0.oSAMPLE_VLD); end
        checks++; if (aud0.oFRAME_ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", aud0.oFRAME_ERR); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (aud1.oAUD_inL !== 16'h0) begin errors++; $display("FAIL rst_i2s_inL got %h exp 0000", aud1.oAUD_inL); end
        checks++; if (aud0.oSAMPLE_VLD !== 1'b0) begin errors++; $display("FAIL rst_post_vld got %b exp 0", aud0.oSAMPLE_VLD); end
    endtask

    task automatic test_basic();
        int v0, e0;
        do_reset();
        send_slot(1'b0, 16'h0000, 16, 1'b0);
        v0 = vcnt[0]; e0 = ecnt[0];
        send_frame(16'h8001, 16'h7FFE, 16, 1'b0);
        checks++; if (vcnt[0] - v0 !== 1) begin errors++; $display("FAIL basic_vld_cnt got %0d exp 1", vcnt[0] - v0); end
        checks++; if (ecnt[0] - e0 !== 0) begin errors++; $display("FAIL basic_err_cnt got %0d exp 0", ecnt[0] - e0); end
        checks++; if (lastl[0] !== 16'h8001) begin errors++; $display("FAIL basic_L got %h exp 8001", lastl[0]); end
        checks++; if (lastr[0] !== 16'h7FFE) begin errors++; $display("FAIL basic_R got %h exp 7ffe", lastr[0]); end
        checks++; if (vcyc[0] - last_rise_cyc !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", vcyc[0] - last_rise_cyc); end
        checks++; if (aud0.oAUD_inL !== 16'h8001 || aud0.oSAMPLE_VLD !== 1'b0) begin
            errors++; $display("FAIL basic_hold got %h/%b exp 8001/0", aud0.oAUD_inL, aud0.oSAMPLE_VLD); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        do_reset();
        send_slot(1'b0, 16'h0000, 16, 1'b0);
        send_frame(16'h5A5A, 16'hA5A5, 16, 1'b0);
        rst_n = 1'b0;
        send_slot(1'b1, 16'h5555, 16, 1'b0);
        send_slot(1'b0, 16'hF0F0, 8, 1'b0);
        checks++; if (aud0.oAUD_inL !== 16'h0) begin errors++; $display("FAIL mid_rst_inL got %h exp 0000", aud0.oAUD_inL); end
        rst_n = 1'b1;
        v0 = vcnt[0];
        send_slot(1'b0, 16'hF0F0, 8, 1'b0);
        checks++; if (vcnt[0] - v0 !== 0) begin errors++; $display("FAIL mid_partial_vld got %0d exp 0", vcnt[0] - v0); end
        send_frame(16'h1234, 16'hABCD, 16, 1'b0);
        checks++; if (vcnt[0] - v0 !== 1) begin errors++; $display("FAIL mid_vld_cnt got %0d exp 1", vcnt[0] - v0); end
        checks++; if (lastl[0] !== 16'h1234) begin errors++; $display("FAIL mid_L got %h exp 1234", lastl[0]); end
        checks++; if (lastr[0] !== 16'hABCD) begin errors++; $display("FAIL mid_R got %h exp abcd", lastr[0]); end
    endtask

    task automatic test_i2s();
        int v1, e1;
        do_reset();
        send_slot(1'b0, 16'h0000, 32, 1'b1);
        v1 = vcnt[1]; e1 = ecnt[1];
        send_frame(16'hFFFF, 16'h0000, 32, 1'b1);
        checks++; if (vcnt[1] - v1 !== 1) begin errors++; $display("FAIL i2s_vld_cnt got %0d exp 1", vcnt[1] - v1); end
        checks++; if (ecnt[1] - e1 !== 0) begin errors++; $display("FAIL i2s_err_cnt got %0d exp 0", ecnt[1] - e1); end
        checks++; if (lastl[1] !== 16'hFFFF) begin errors++; $display("FAIL i2s_L got %h exp ffff", lastl[1]); end
        checks++; if (lastr[1] !== 16'h0000) begin errors++; $display("FAIL i2s_R got %h exp 0000", lastr[1]); end
    endtask

    task automatic test_short_slot();
        int v0, e0;
        do_reset();
        send_slot(1'b0, 16'h0000, 16, 1'b0);
        v0 = vcnt[0]; e0 = ecnt[0];
        send_slot(1'b1, 16'h2468, 10, 1'b0);
        send_slot(1'b0, 16'h1357, 16, 1'b0);
        checks++; if (ecnt[0] - e0 !== 1) begin errors++; $display("FAIL short_err_cnt got %0d exp 1", ecnt[0] - e0); end
        checks++; if (vcnt[0] - v0 !== 0) begin errors++; $display("FAIL short_drop_vld got %0d exp 0", vcnt[0] - v0); end
        send_frame(16'h0F0F, 16'hF0F0, 16, 1'b0);
        checks++; if (vcnt[0] - v0 !== 1) begin errors++; $display("FAIL short_next_vld got %0d exp 1", vcnt[0] - v0); end
        checks++; if (lastl[0] !== 16'h0F0F || lastr[0] !== 16'hF0F0) begin
            errors++; $display("FAIL short_next_LR got %h/%h exp 0f0f/f0f0", lastl[0], lastr[0]); end
        checks++; if (ecnt[0] - e0 !== 1) begin errors++; $display("FAIL short_next_err got %0d exp 1", ecnt[0] - e0); end
    endtask

    task automatic test_narrow_slot();
        int v0, e0;
        do_reset();
        send_slot(1'b0, 16'h0000, 16, 1'b0);
        v0 = vcnt[0]; e0 = ecnt[0];
        send_frame(16'hFFFF, 16'h8888, 12, 1'b0);
        send_slot(1'b1, 16'h4444, 12, 1'b0);
        send_bit(1'b0, 1'b1);
        checks++; if (ecnt[0] - e0 !== 3) begin errors++; $display("FAIL narrow_err_cnt got %0d exp 3", ecnt[0] - e0); end
        checks++; if (vcnt[0] - v0 !== 0) begin errors++; $display("FAIL narrow_vld_cnt got %0d exp 0", vcnt[0] - v0); end
    endtask

    task automatic test_left_low();
        int v2;
        do_reset();
        send_slot(1'b0, 16'h0000, 16, 1'b0);
        v2 = vcnt[2];
        send_frame(16'h8001, 16'h7FFE, 16, 1'b0);
        checks++; if (vcnt[2] - v2 !== 1) begin errors++; $display("FAIL lowleft_vld_cnt got %0d exp 1", vcnt[2] - v2); end
        checks++; if (lastl[2] !== 16'h8001) begin errors++; $display("FAIL lowleft_L got %h exp 8001", lastl[2]); end
        checks++; if (lastr[2] !== 16'h7FFE) begin errors++; $display("FAIL lowleft_R got %h exp 7ffe", lastr[2]); end
    endtask

`ifdef AUDIO_RX_PEAK_EN
    task automatic test_peak();
        do_reset();
        checks++; if (aud0.oPEAK_L !== 15'h0) begin errors++; $display("FAIL peak_rst got %h exp 0000", aud0.oPEAK_L); end
        send_slot(1'b0, 16'h0000, 16, 1'b0);
        send_frame(16'h8000, 16'h0000, 16, 1'b0);
        checks++; if (aud0.oPEAK_L !== 15'h7FFF) begin errors++; $display("FAIL peak_min_L got %h exp 7fff", aud0.oPEAK_L); end
        checks++; if (aud0.oPEAK_R !== 15'h0000) begin errors++; $display("FAIL peak_min_R got %h exp 0000", aud0.oPEAK_R); end
        send_frame(16'h0064, 16'hFFFF, 16, 1'b0);
        checks++; if (aud0.oPEAK_L !== 15'h7FFF) begin errors++; $display("FAIL peak_hold_L got %h exp 7fff", aud0.oPEAK_L); end
        checks++; if (aud0.oPEAK_R !== 15'h0001) begin errors++; $display("FAIL peak_neg1_R got %h exp 0001", aud0.oPEAK_R); end
        peak_clr = 1'b1;
        send_frame(16'hFFFB, 16'h0003, 16, 1'b0);
        peak_clr = 1'b0;
        checks++; if (aud0.oPEAK_L !== 15'h0005) begin errors++; $display("FAIL peak_clr_L got %h exp 0005", aud0.oPEAK_L); end
        checks++; if (aud0.oPEAK_R !== 15'h0003) begin errors++; $display("FAIL peak_clr_R got %h exp 0003", aud0.oPEAK_R); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_reset_mid_frame();
        test_i2s();
        test_short_slot();
        test_narrow_slot();
        test_left_low();
`ifdef AUDIO_RX_PEAK_EN
        test_peak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
